// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART hex reporter.
//   tx_state_t : 8N1 frame states
//   ASCII_CR/LF: line terminator characters
//   hex2ascii  : 4-bit nibble -> lowercase ASCII hex character
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // 0-9 -> '0'-'9' (0x30..0x39), 10-15 -> 'a'-'f' (0x61..0x66)
  function automatic logic [7:0] hex2ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return 8'h30 + {4'h0, nibble};
    end else begin
      return 8'h57 + {4'h0, nibble};
    end
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// One 8N1 UART frame transmitter with its own baud counter.
//   gclk       in   system clock
//   rst        in   synchronous, active-high reset
//   byte_data  in   character to send
//   byte_valid in   byte_data is valid
//   byte_ready out  a byte is accepted this cycle (idle, or last cycle of a stop bit)
//   tx         out  registered serial line, idles high
// Accepting during the final stop-bit cycle lets consecutive frames run with no gap.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int DIV = 868
) (
  input  logic       gclk,
  input  logic       rst,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx
);

  localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d;
  logic             bit_end;

  assign bit_end    = (baud_q == CNT_LAST);
  assign byte_ready = (state_q == IDLE) || ((state_q == STOP) && bit_end);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (byte_valid) begin
          state_d = START;
          shift_d = byte_data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (byte_valid) begin
            state_d = START;
            shift_d = byte_data;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge gclk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
    end
  end

endmodule

// File: rtl/uart_hex_reporter.sv
// Serialises a DATA_W-bit word as lowercase ASCII hex over 8N1 UART,
// optionally followed by CR/LF; doubles as a pin loopback when idle.
//   gclk      in   system clock
//   rst       in   synchronous, active-high reset
//   in_data   in   word to report (captured on the transfer edge)
//   in_valid  in   in_data is valid
//   in_ready  out  word accepted when in_valid & in_ready on a gclk edge
//   loopback  in   while idle: uart_rx follows the synchronised uart_tx
//   busy      out  a report is in progress
//   uart_tx   in   host->FPGA serial line (asynchronous)
//   uart_rx   out  FPGA->host serial line, idles high
module uart_hex_reporter
  import uart_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int DATA_W      = 256,
  parameter int APPEND_CRLF = 1,
  parameter int MSN_FIRST   = 1
) (
  input  logic              gclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              loopback,
  output logic              busy,
  input  logic              uart_tx,
  output logic              uart_rx
);

  localparam int DIV     = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int NIBBLES = DATA_W / 4;
  localparam int N_CHARS = NIBBLES + 2 * APPEND_CRLF;
  localparam int CHAR_W  = $clog2(NIBBLES + 2);

  localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(N_CHARS - 1);
  localparam logic [CHAR_W-1:0] CHAR_CR   = CHAR_W'(NIBBLES);

  // shreg holds the nibbles still to send, with the next one at its head.
  // char_cnt is the index of the character currently on the line.
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] in_shift, sh_shift;
  logic [3:0]        in_head, sh_head;
  logic [CHAR_W-1:0] char_cnt, next_idx;
  logic [7:0]        next_char, byte_data;
  logic              more, transfer, byte_valid, byte_ready;
  logic              tx_line, lb_line, tx_meta, tx_sync;

  if (MSN_FIRST != 0) begin : g_msn_first
    assign in_head  = in_data[DATA_W-1 -: 4];
    assign sh_head  = shreg[DATA_W-1 -: 4];
    assign in_shift = in_data << 4;
    assign sh_shift = shreg << 4;
  end else begin : g_lsn_first
    assign in_head  = in_data[3:0];
    assign sh_head  = shreg[3:0];
    assign in_shift = in_data >> 4;
    assign sh_shift = shreg >> 4;
  end

  assign in_ready = ~busy & ~loopback & ~rst;
  assign transfer = in_valid & in_ready;
  assign more     = (char_cnt != CHAR_LAST);
  assign next_idx = char_cnt + 1'b1;

  always_comb begin
    next_char = hex2ascii(sh_head);
    if (APPEND_CRLF != 0) begin
      if (next_idx == CHAR_CR) begin
        next_char = ASCII_CR;
      end else if (next_idx > CHAR_CR) begin
        next_char = ASCII_LF;
      end
    end
  end

  // The first character comes straight from in_data so the start bit
  // leaves on the transfer edge itself; later ones come from shreg.
  assign byte_valid = busy ? more : transfer;
  assign byte_data  = busy ? next_char : hex2ascii(in_head);

  uart_byte_tx #(
    .DIV(DIV)
  ) u_byte_tx (
    .gclk      (gclk),
    .rst       (rst),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .tx        (tx_line)
  );

  always_ff @(posedge gclk) begin
    if (rst) begin
      busy     <= 1'b0;
      char_cnt <= '0;
      shreg    <= '0;
      lb_line  <= 1'b1;
      tx_meta  <= 1'b1;
      tx_sync  <= 1'b1;
    end else begin
      // NOTE: uart_tx is asynchronous; only tx_sync (second flop) may feed logic.
      tx_meta <= uart_tx;
      tx_sync <= tx_meta;
      lb_line <= (~busy & loopback) ? tx_sync : 1'b1;
      if (transfer) begin
        busy     <= 1'b1;
        char_cnt <= '0;
        shreg    <= in_shift;
      end else if (busy && byte_ready) begin
        if (more) begin
          char_cnt <= next_idx;
          shreg    <= sh_shift;
        end else begin
          busy     <= 1'b0;
          char_cnt <= '0;
        end
      end
    end
  end

  // Both sources are registers and never active together: lb_line is held
  // high for the whole report and tx_line is high whenever loopback is live.
  assign uart_rx = tx_line & lb_line;

endmodule

// File: tb/tb_uart_hex_reporter.sv
// Directed bench for uart_hex_reporter with CLK_HZ=8, BAUD=1 (DIV=8).
// dut_a: DATA_W=16, MSN first, CR/LF appended.  dut_b: LSN first, no CR/LF.
module tb_uart_hex_reporter;

  localparam int DIV = 8;
  typedef logic [7:0] byte_q_t[$];

  logic        gclk = 1'b0;
  logic        rst  = 1'b1;
  logic [15:0] a_data = '0, b_data = '0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_lb = 1'b0, b_lb = 1'b0;
  logic        a_tx = 1'b1, b_tx = 1'b1;
  logic        a_ready, b_ready, a_busy, b_busy, a_rx, b_rx;

  int checks = 0;
  int fails  = 0;

  always #5 gclk = ~gclk;

  uart_hex_reporter #(
    .CLK_HZ(8), .BAUD(1), .DATA_W(16), .APPEND_CRLF(1), .MSN_FIRST(1)
  ) dut_a (
    .gclk(gclk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .loopback(a_lb), .busy(a_busy), .uart_tx(a_tx), .uart_rx(a_rx)
  );

  uart_hex_reporter #(
    .CLK_HZ(8), .BAUD(1), .DATA_W(16), .APPEND_CRLF(0), .MSN_FIRST(0)
  ) dut_b (
    .gclk(gclk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .loopback(b_lb), .busy(b_busy), .uart_tx(b_tx), .uart_rx(b_rx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rx_of(input bit sel_b);
    return sel_b ? b_rx : a_rx;
  endfunction

  function automatic logic busy_of(input bit sel_b);
    return sel_b ? b_busy : a_busy;
  endfunction

  function automatic logic ready_of(input bit sel_b);
    return sel_b ? b_ready : a_ready;
  endfunction

  // Waits (bounded) for a start bit, then samples each bit at its middle.
  task automatic rx_byte(input bit sel_b, input int budget, output logic [7:0] data,
                         output bit found, output bit frame_ok);
    data     = '0;
    found    = 1'b0;
    frame_ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge gclk);
      if (rx_of(sel_b) == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) return;
    repeat (DIV / 2) @(negedge gclk);
    frame_ok = (rx_of(sel_b) === 1'b0);
    for (int b = 0; b < 8; b++) begin
      repeat (DIV) @(negedge gclk);
      data[b] = rx_of(sel_b);
    end
    repeat (DIV) @(negedge gclk);
    frame_ok = frame_ok && (rx_of(sel_b) === 1'b1);
  endtask

  task automatic expect_bytes(input bit sel_b, input string tag, input byte_q_t exp);
    logic [7:0] d;
    bit found, frame_ok;
    foreach (exp[i]) begin
      rx_byte(sel_b, 40 * DIV, d, found, frame_ok);
      check($sformatf("%s found[%0d]", tag, i), 32'(found), 32'd1);
      if (!found) return;
      check($sformatf("%s byte[%0d]", tag, i), 32'(d), 32'(exp[i]));
      check($sformatf("%s framing[%0d]", tag, i), 32'(frame_ok), 32'd1);
    end
  endtask

  // Counts busy cycles starting at the first negedge after the transfer edge;
  // returns in_ready on the first non-busy cycle.
  task automatic count_busy(input bit sel_b, output int n, output logic rdy);
    n   = 0;
    rdy = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge gclk);
      if (busy_of(sel_b)) begin
        n++;
      end else begin
        rdy = ready_of(sel_b);
        break;
      end
    end
  endtask

  // Presents a word at a negedge, waits (bounded) for in_ready, and drops
  // in_valid just after the transfer edge.
  task automatic send(input bit sel_b, input logic [15:0] w, output bit ok);
    @(negedge gclk);
    if (sel_b) begin
      b_data = w; b_valid = 1'b1;
    end else begin
      a_data = w; a_valid = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (ready_of(sel_b)) begin
        ok = 1'b1;
        break;
      end
      @(negedge gclk);
    end
    @(posedge gclk);
    #1;
    if (sel_b) b_valid = 1'b0;
    else       a_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t    q;
    bit         ok, found, frame_ok;
    int         n, bad;
    logic       rdy;
    logic [7:0] d;
    logic [15:0] pat;

    // Reset values
    repeat (3) @(posedge gclk);
    @(negedge gclk);
    check("reset uart_rx", a_rx, 1'b1);
    check("reset in_ready", a_ready, 1'b0);
    check("reset busy", a_busy, 1'b0);
    rst = 1'b0;
    @(negedge gclk);
    check("post-reset in_ready a", a_ready, 1'b1);
    check("post-reset in_ready b", b_ready, 1'b1);

    // 1: BEEF, MSN first, with CR/LF
    send(1'b0, 16'hBEEF, ok);
    check("t1 accept", 32'(ok), 32'd1);
    q = {8'h62, 8'h65, 8'h65, 8'h66, 8'h0D, 8'h0A};
    fork
      expect_bytes(1'b0, "t1", q);
      begin
        count_busy(1'b0, n, rdy);
        check("t1 busy cycles", n, 480);
        check("t1 ready after report", rdy, 1'b1);
      end
      begin
        @(negedge gclk);
        check("t1 start bit latency", a_rx, 1'b0);
        check("t1 busy at start", a_busy, 1'b1);
        check("t1 ready low at start", a_ready, 1'b0);
      end
    join

    // 2: 0123, LS nibble first, no terminator
    send(1'b1, 16'h0123, ok);
    check("t2 accept", 32'(ok), 32'd1);
    q = {8'h33, 8'h32, 8'h31, 8'h30};
    fork
      expect_bytes(1'b1, "t2", q);
      begin
        count_busy(1'b1, n, rdy);
        check("t2 busy cycles", n, 320);
        check("t2 ready after report", rdy, 1'b1);
      end
    join
    rx_byte(1'b1, 30, d, found, frame_ok);
    check("t2 no terminator", 32'(found), 32'd0);

    // 3: in_valid held across two back-to-back words
    q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A,
         8'h61, 8'h35, 8'h63, 8'h30, 8'h0D, 8'h0A};
    fork
      begin
        @(negedge gclk);
        a_data  = 16'h1234;
        a_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
          if (a_ready) break;
          @(negedge gclk);
        end
        @(posedge gclk);
        #1;
        a_data = 16'hA5C0;
        for (int i = 0; i < 2000; i++) begin
          @(negedge gclk);
          if (a_ready) break;
        end
        @(posedge gclk);
        #1;
        a_valid = 1'b0;
      end
      expect_bytes(1'b0, "t3", q);
      begin
        bad = 0;
        for (int i = 0; i < 2 * 480 + 20; i++) begin
          @(negedge gclk);
          if (a_busy && a_ready) bad++;
        end
        check("t3 ready low while busy", bad, 0);
      end
    join
    rx_byte(1'b0, 100, d, found, frame_ok);
    check("t3 no third report", 32'(found), 32'd0);
    check("t3 idle after", a_busy, 1'b0);

    // 4: reset at cycle 100 of a report, then a fresh word
    send(1'b0, 16'hBEEF, ok);
    check("t4 accept", 32'(ok), 32'd1);
    repeat (100) @(negedge gclk);
    check("t4 rx before reset", a_rx, 1'b0);
    rst = 1'b1;
    @(negedge gclk);
    check("t4 rx after reset", a_rx, 1'b1);
    check("t4 busy after reset", a_busy, 1'b0);
    check("t4 ready during reset", a_ready, 1'b0);
    rst = 1'b0;
    @(negedge gclk);
    check("t4 ready after release", a_ready, 1'b1);
    check("t4 rx idle after release", a_rx, 1'b1);
    send(1'b0, 16'h0F9A, ok);
    check("t4 accept new", 32'(ok), 32'd1);
    q = {8'h30, 8'h66, 8'h39, 8'h61, 8'h0D, 8'h0A};
    fork
      expect_bytes(1'b0, "t4", q);
      begin
        count_busy(1'b0, n, rdy);
        check("t4 busy cycles", n, 480);
      end
    join

    // 5: loopback in IDLE
    @(negedge gclk);
    a_lb = 1'b1;
    a_tx = 1'b1;
    repeat (4) @(negedge gclk);
    check("t5 ready low in loopback", a_ready, 1'b0);
    check("t5 rx idle in loopback", a_rx, 1'b1);
    a_data  = 16'h5555;
    a_valid = 1'b1;
    pat = 16'b1100_1010_0011_0110;
    for (int k = 0; k < 19; k++) begin
      if (k >= 3) check($sformatf("t5 echo[%0d]", k - 3), a_rx, pat[k-3]);
      if (k < 16) a_tx = pat[k];
      @(negedge gclk);
    end
    check("t5 in_valid ignored", a_busy, 1'b0);
    a_valid = 1'b0;
    a_tx    = 1'b0;
    repeat (4) @(negedge gclk);
    check("t5 rx follows low", a_rx, 1'b0);
    a_lb = 1'b0;
    @(negedge gclk);
    check("t5 exit forces idle", a_rx, 1'b1);
    a_tx = 1'b1;

    // 6: loopback raised mid-report with uart_tx held low
    send(1'b0, 16'hC0DE, ok);
    check("t6 accept", 32'(ok), 32'd1);
    q = {8'h63, 8'h30, 8'h64, 8'h65, 8'h0D, 8'h0A};
    fork
      expect_bytes(1'b0, "t6", q);
      begin
        count_busy(1'b0, n, rdy);
        check("t6 busy cycles", n, 480);
        check("t6 ready held by loopback", rdy, 1'b0);
      end
      begin
        repeat (50) @(negedge gclk);
        a_lb = 1'b1;
        a_tx = 1'b0;
      end
    join
    @(negedge gclk);
    check("t6 loopback after report", a_rx, 1'b0);
    a_lb = 1'b0;
    a_tx = 1'b1;
    @(negedge gclk);
    check("t6 loopback exit", a_rx, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
